// File: rtl/com_regs_pkg.sv
// Shared definitions for the COM_* register-bank link: frame geometry,
// responder register map and the SPI initiator state encoding.
package com_regs_pkg;

   localparam int unsigned XFER_BITS = 32;
   localparam int unsigned ADDR_BITS = 8;
   localparam int unsigned VAL_BITS  = 24;
   localparam int unsigned BIT_W     = $clog2(XFER_BITS);

   localparam logic [ADDR_BITS-1:0] RD_ONLY_MASK = 8'h80;

   localparam logic [ADDR_BITS-1:0] REG_LED           = 8'd7;
   localparam logic [ADDR_BITS-1:0] REG_COUNT_UP      = 8'd9;
   localparam logic [ADDR_BITS-1:0] REG_COUNT_DOWN    = 8'd10;
   localparam logic [ADDR_BITS-1:0] REG_COUNT_RUNDOWN = 8'd11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LO,
      ST_HI,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

   // Assemble the outgoing frame; read-only requests carry the no-write flag in the address MSB.
   function automatic logic [XFER_BITS-1:0] build_frame(input logic [ADDR_BITS-1:0] a,
                                                        input logic [VAL_BITS-1:0]  v,
                                                        input logic                 rd_only);
      logic [ADDR_BITS-1:0] a_eff;
      a_eff = rd_only ? (a | RD_ONLY_MASK) : a;
      return {a_eff, v};
   endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchroniser for an asynchronous active-low line plus a
// registered one-cycle pulse on each falling edge of the synchronised value.
module sync_fall_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic fall_pulse
);

   logic meta;
   logic sync;
   logic hist;

   // Synchronise, keep one cycle of history, and flag a 1->0 transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta       <= 1'b1;
         sync       <= 1'b1;
         hist       <= 1'b1;
         fall_pulse <= 1'b0;
      end else begin
         meta       <= async_in;
         sync       <= meta;
         hist       <= sync;
         fall_pulse <= hist & ~sync;
      end
   end

endmodule

// File: rtl/spi_reg_master.sv
// SPI initiator for the ADC board register bank: one 32-bit frame
// (address byte + 24-bit value, MSB first) per request, 24-bit readback.
import com_regs_pkg::*;

module spi_reg_master #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [VAL_BITS-1:0]  wdata,
   input  logic                 rd_only,
   output logic                 busy,
   output logic                 done,
   output logic [VAL_BITS-1:0]  rdata,
   output logic                 com_clk,
   output logic                 com_cs,
   output logic                 com_mosi,
   input  logic                 com_miso,
   input  logic                 com_interupt,
   output logic                 irq_pulse
);

   localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   generate
      if (CLK_DIV < 2) begin : g_bad_clk_div
         $error("spi_reg_master: CLK_DIV must be at least 2");
      end
      if (CS_GAP < 1) begin : g_bad_cs_gap
         $error("spi_reg_master: CS_GAP must be at least 1");
      end
   endgenerate

   spi_state_e           state;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic [XFER_BITS-1:0] tx;
   logic [VAL_BITS-1:0]  rx;
   logic [XFER_BITS-1:0] frame_c;
   logic                 div_last_c;
   logic                 rx_slot_c;

   // Frame image and per-state timing decodes.
   always_comb begin
      frame_c    = build_frame(addr, wdata, rd_only);
      div_last_c = (cnt == CNT_W'(CLK_DIV - 1));
      rx_slot_c  = (bit_idx >= BIT_W'(ADDR_BITS - 1)) && (bit_idx <= BIT_W'(XFER_BITS - 2));
   end

   // Frame sequencer: SCLK half-periods, bit counting, MOSI shift-out and MISO capture.
   // MOSI is advanced on the rising SCLK edge so it is stable across the responder's falling-edge capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         tx       <= '0;
         rx       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rdata    <= '0;
         com_clk  <= 1'b1;
         com_cs   <= 1'b1;
         com_mosi <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !busy) begin
                  tx       <= frame_c;
                  com_mosi <= frame_c[XFER_BITS-1];
                  com_cs   <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  bit_idx  <= '0;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (div_last_c) begin
                  cnt     <= '0;
                  com_clk <= 1'b0;
                  state   <= ST_LO;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_LO: begin
               if (div_last_c) begin
                  cnt     <= '0;
                  com_clk <= 1'b1;
                  state   <= ST_HI;
                  if (rx_slot_c) begin
                     rx <= {rx[VAL_BITS-2:0], com_miso};
                  end
                  if (bit_idx != BIT_W'(XFER_BITS - 1)) begin
                     com_mosi <= tx[XFER_BITS-2];
                     tx       <= {tx[XFER_BITS-2:0], 1'b0};
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HI: begin
               if (div_last_c) begin
                  cnt <= '0;
                  if (bit_idx == BIT_W'(XFER_BITS - 1)) begin
                     state <= ST_HOLD;
                  end else begin
                     bit_idx <= bit_idx + BIT_W'(1);
                     com_clk <= 1'b0;
                     state   <= ST_LO;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (div_last_c) begin
                  cnt      <= '0;
                  com_cs   <= 1'b1;
                  com_mosi <= 1'b0;
                  state    <= ST_GAP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt == CNT_W'(CS_GAP - 1)) begin
                  cnt   <= '0;
                  rdata <= rx;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   sync_fall_detect u_irq_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (com_interupt),
      .fall_pulse (irq_pulse)
   );

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master with a behavioural register-bank responder.
module tb_spi_reg_master;
   import com_regs_pkg::*;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned CS_GAP  = 8;
   localparam int unsigned LATENCY = 1 + 66 * CLK_DIV + CS_GAP;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  addr = '0;
   logic [23:0] wdata = '0;
   logic        rd_only = 1'b0;
   logic        busy;
   logic        done;
   logic [23:0] rdata;
   logic        com_clk;
   logic        com_cs;
   logic        com_mosi;
   logic        com_miso;
   logic        com_interupt = 1'b1;
   logic        irq_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   spi_reg_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .addr         (addr),
      .wdata        (wdata),
      .rd_only      (rd_only),
      .busy         (busy),
      .done         (done),
      .rdata        (rdata),
      .com_clk      (com_clk),
      .com_cs       (com_cs),
      .com_mosi     (com_mosi),
      .com_miso     (com_miso),
      .com_interupt (com_interupt),
      .irq_pulse    (irq_pulse)
   );

   always #5 clk = ~clk;

   // ---------------- responder model ----------------
   logic [31:0] m_shift = '0;
   logic [23:0] m_out = '0;
   logic [31:0] m_last_frame = '0;
   int          m_count = 0;
   int          m_frames = 0;
   int          m_aborts = 0;
   logic        cs_prev = 1'b1;
   logic [23:0] m_regs [16] = '{7: 24'h000000, 9: 24'h123456, 10: 24'h00FF00,
                                11: 24'h0A0A0A, default: 24'h000000};

   assign com_miso = m_out[23];

   function automatic logic mapped(input logic [7:0] a);
      return (a == REG_LED) || (a == REG_COUNT_UP) || (a == REG_COUNT_DOWN) ||
             (a == REG_COUNT_RUNDOWN);
   endfunction

   function automatic logic [23:0] model_read(input logic [7:0] a);
      logic [7:0] a7;
      a7 = a & 8'h7F;
      return mapped(a7) ? m_regs[a7[3:0]] : 24'h000000;
   endfunction

   // Shift on SCLK fall, load readback after the address byte, commit on CS rise after a full frame.
   always @(negedge com_clk or com_cs) begin
      if (com_cs && !cs_prev) begin
         if (m_count == 32) begin
            m_frames     <= m_frames + 1;
            m_last_frame <= m_shift;
            if (!m_shift[31] && mapped(m_shift[31:24]))
               m_regs[m_shift[27:24]] <= m_shift[23:0];
         end else begin
            m_aborts <= m_aborts + 1;
         end
      end else if (!com_cs && cs_prev) begin
         m_count <= 0;
         m_out   <= '0;
      end else if (!com_cs && !com_clk) begin
         m_shift <= {m_shift[30:0], com_mosi};
         m_count <= m_count + 1;
         if (m_count == 7) m_out <= model_read({m_shift[6:0], com_mosi});
         else              m_out <= {m_out[22:0], 1'b0};
      end
      cs_prev <= com_cs;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one request and wait for done; inputs are scrambled after acceptance.
   task automatic run_frame(input string tag, input logic [7:0] a, input logic [23:0] w,
                            input logic r, output int lat, output logic [23:0] got);
      lat = -1;
      got = 'x;
      @(negedge clk);
      addr = a; wdata = w; rd_only = r; start = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0; addr = ~a; wdata = ~w; rd_only = ~r;
            check({tag, " busy after accept"}, busy, 1'b1);
            check({tag, " cs after accept"}, com_cs, 1'b0);
         end
         if (done) begin
            lat = k;
            got = rdata;
            check({tag, " busy at done"}, busy, 1'b0);
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic [23:0] wdata;
      logic        rd_only;
      logic [31:0] exp_mosi;
      logic [23:0] exp_rdata;
      logic [7:0]  chk_addr;
      logic [23:0] chk_val;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [23:0] got;
      int          f0, a0, k_done, cs_high, dones, extra;
      string       tag;

      vecs[0] = '{REG_LED,       24'h000005, 1'b0, 32'h07000005, 24'h000000, REG_LED,        24'h000005};
      vecs[1] = '{REG_COUNT_UP,  24'hFFFFFF, 1'b1, 32'h89FFFFFF, 24'h123456, REG_COUNT_UP,   24'h123456};
      vecs[2] = '{REG_LED,       24'hABCDEF, 1'b0, 32'h07ABCDEF, 24'h000005, REG_LED,        24'hABCDEF};
      vecs[3] = '{REG_LED,       24'h000000, 1'b1, 32'h87000000, 24'hABCDEF, REG_LED,        24'hABCDEF};
      vecs[4] = '{REG_COUNT_DOWN, 24'h55AA55, 1'b0, 32'h0A55AA55, 24'h00FF00, REG_COUNT_DOWN, 24'h55AA55};
      vecs[5] = '{REG_COUNT_RUNDOWN, 24'h800001, 1'b1, 32'h8B800001, 24'h0A0A0A, REG_COUNT_RUNDOWN, 24'h0A0A0A};
      vecs[6] = '{8'h0C,         24'h777777, 1'b0, 32'h0C777777, 24'h000000, REG_LED,        24'hABCDEF};

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset com_cs", com_cs, 1'b1);
      check("reset com_clk", com_clk, 1'b1);
      check("reset com_mosi", com_mosi, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset rdata", rdata, 24'h0);
      check("reset irq_pulse", irq_pulse, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven frames
      for (int i = 0; i < 7; i++) begin
         tag = $sformatf("vec%0d", i);
         f0 = m_frames;
         run_frame(tag, vecs[i].addr, vecs[i].wdata, vecs[i].rd_only, lat, got);
         check({tag, " latency"}, lat, LATENCY);
         check({tag, " rdata"}, got, vecs[i].exp_rdata);
         check({tag, " mosi frame"}, m_last_frame, vecs[i].exp_mosi);
         check({tag, " frame count"}, m_frames - f0, 1);
         check({tag, " sclk falls"}, m_count, 32);
         check({tag, " reg value"}, m_regs[vecs[i].chk_addr[3:0]], vecs[i].chk_val);
         repeat (3) @(negedge clk);
      end

      // start during a frame is ignored; start on the done cycle launches the next frame
      f0 = m_frames; dones = 0; cs_high = 0; k_done = -1; got = 'x;
      @(negedge clk);
      addr = REG_COUNT_UP; wdata = 24'h000000; rd_only = 1'b1; start = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start = (k == 10);
         if (k == 10) begin addr = REG_LED; wdata = 24'hDEAD00; rd_only = 1'b0; end
         if (k > 1 && com_cs) cs_high++;
         if (done) begin dones++; k_done = k; got = rdata; break; end
      end
      check("busy-start latency", k_done, LATENCY);
      check("busy-start rdata", got, 24'h123456);
      check("busy-start mosi frame", m_last_frame, 32'h89000000);
      addr = REG_LED; wdata = 24'h000000; rd_only = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b busy next cycle", busy, 1'b1);
      check("b2b cs low next cycle", com_cs, 1'b0);
      check("b2b cs high cycles", cs_high, CS_GAP + 1);
      k_done = -1;
      for (int k = 2; k <= 400; k++) begin
         @(negedge clk);
         if (done) begin dones++; k_done = k; got = rdata; break; end
      end
      check("b2b latency", k_done, LATENCY);
      check("b2b rdata", got, 24'hABCDEF);
      extra = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      check("no queued frame", extra, 0);
      check("b2b done count", dones, 2);
      check("b2b frame count", m_frames - f0, 2);
      check("ignored write kept led", m_regs[7], 24'hABCDEF);

      // Reset at the 12th SCLK fall
      f0 = m_frames; a0 = m_aborts;
      @(negedge clk);
      addr = REG_LED; wdata = 24'h111111; rd_only = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (m_count == 12) break;
         @(negedge clk);
      end
      check("reached fall 12", m_count, 12);
      check("sclk low before reset", com_clk, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async rst com_cs", com_cs, 1'b1);
      check("async rst com_clk", com_clk, 1'b1);
      check("async rst busy", busy, 1'b0);
      check("async rst rdata", rdata, 24'h0);
      check("async rst no frame", m_frames - f0, 0);
      check("async rst abort seen", m_aborts - a0, 1);
      check("async rst led kept", m_regs[7], 24'hABCDEF);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame("post-reset", REG_LED, 24'h000042, 1'b0, lat, got);
      check("post-reset latency", lat, LATENCY);
      check("post-reset rdata", got, 24'hABCDEF);
      check("post-reset mosi frame", m_last_frame, 32'h07000042);
      check("post-reset led", m_regs[7], 24'h000042);

      // Interrupt pulses overlapping a frame
      fork
         begin
            int          l2;
            logic [23:0] g2;
            run_frame("irq-frame", REG_COUNT_UP, 24'h0, 1'b1, l2, g2);
            check("irq-frame latency", l2, LATENCY);
            check("irq-frame rdata", g2, 24'h123456);
         end
         begin
            int total;
            total = 0;
            for (int rep = 0; rep < 2; rep++) begin
               int first, lo_pulses, hi_pulses;
               first = -1; lo_pulses = 0; hi_pulses = 0;
               @(negedge clk);
               com_interupt = 1'b0;
               for (int k = 1; k <= 40; k++) begin
                  @(negedge clk);
                  if (irq_pulse) begin
                     lo_pulses++;
                     if (first < 0) first = k;
                  end
               end
               com_interupt = 1'b1;
               for (int k = 0; k < 20; k++) begin
                  @(negedge clk);
                  if (irq_pulse) hi_pulses++;
               end
               check($sformatf("irq%0d delay in 2..3 (got %0d)", rep, first),
                     (first >= 2 && first <= 3), 1'b1);
               check($sformatf("irq%0d pulses while low", rep), lo_pulses, 1);
               check($sformatf("irq%0d pulses after release", rep), hi_pulses, 0);
               total += lo_pulses + hi_pulses;
            end
            check("irq total pulses", total, 2);
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
